cascade_limit_counter: RTL
==========================

Name: cascade_limit_counter

Overview:
- Parametrised chain of NUM_DIGITS limit counters, one per digit, with ripple carry and borrow between digits.
- Each digit counts 0..its own runtime limit, in either direction, with synchronous load and terminal handling.
- Serves as the time/value core for stopwatch, timer and clock displays, replacing hand-wired chains of single-digit counters.
- Output feeds the seven-segment display path directly, one DIGIT_W-bit field per digit.

Parameters:
- DIGIT_W, 4, width of one digit field.
- NUM_DIGITS, 4, number of cascaded digits. Digit 0 is least significant and sits in bits [DIGIT_W-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable. Gates step only.
- step  input  1  one-cycle count request, sampled at the rising edge.
- dir  input  1  1 = count up, 0 = count down.
- wrap_mode  input  1  1 = wrap at terminal, 0 = stop at terminal.
- load  input  1  synchronous load of load_value.
- load_value  input  NUM_DIGITS*DIGIT_W  per-digit load data.
- init_value  input  NUM_DIGITS*DIGIT_W  per-digit value applied while reset is high.
- limit  input  NUM_DIGITS*DIGIT_W  per-digit maximum value, may change at runtime.
- value  output  NUM_DIGITS*DIGIT_W  registered count.
- carry_pulse  output  1  registered one-cycle pulse on wrap, either direction.
- at_terminal  output  1  combinational: all digits at limit when dir=1, all digits zero when dir=0.
- stopped  output  1  registered sticky flag: a step occurred at terminal with wrap_mode=0.

Behaviour:
- Reset (async, high): value <= init_value, carry_pulse <= 0, stopped <= 0. Takes effect immediately, mid-count included. First count is evaluated at the first edge after reset falls.
- Priority at each rising edge: reset > load > (en & step & ~stopped) > hold.
- Load: each digit is loaded with min(load_value_i, limit_i). Load clears stopped and forces carry_pulse=0. step is ignored in a load cycle.
- Count: an active step updates value at that edge (latency 1). All digits are resolved combinationally in the same cycle; there is no multi-cycle ripple.
- Up (dir=1):
  - Digit 0 is stepped.
  - Digit i>0 is stepped when every lower digit satisfies value_j >= limit_j.
  - A stepped digit with value_i >= limit_i goes to 0; otherwise it increments by 1.
- Down (dir=0):
  - Digit i>0 is stepped when every lower digit equals 0.
  - A stepped digit at 0 goes to limit_i; otherwise it decrements by 1.
  - A digit above limit_i decrements normally.
- Terminal step: an active step while at_terminal=1.
  - wrap_mode=1: the natural cascade result applies (up gives all zeros, down gives all limits). carry_pulse=1 for exactly the cycle after the edge, coincident with the new value.
  - wrap_mode=0: value holds and stopped <= 1. Further steps are ignored until load or reset. carry_pulse stays 0.
- carry_pulse is 0 in every cycle not following a wrapping step. Back-to-back wrapping steps give back-to-back pulses.
- en=0 or step=0: value holds and carry_pulse <= 0. Load still works with en=0.
- dir and wrap_mode are sampled at the stepping edge only. Changing dir while stopped=1 does not clear stopped.
- at_terminal follows dir immediately, with no registering.
- limit_i = 0: that digit stays 0 and always passes carry/borrow through.
- Arithmetic is modulo 2^DIGIT_W per digit and is never reached when value_i <= limit_i. No cross-digit overflow beyond the defined cascade.

Test Plan:
- Params 4/4, limit=16'h5959, value=16'h0959, dir=1, one step -> value=16'h1000 at next edge; carry_pulse=0.
- value=16'h5959, dir=1, wrap_mode=1, step -> value=16'h0000, carry_pulse=1 for one cycle then 0; at_terminal toggles 1->0.
- value=16'h1000, dir=0, step -> 16'h0959. Continue from 16'h0000 with wrap_mode=1 -> 16'h5959 and carry_pulse=1.
- value=16'h0000, dir=0, wrap_mode=0, three steps -> value stays 16'h0000, stopped=1 after first step. Then load=1, load_value=16'h0130 -> value=16'h0130, stopped=0.
- Clipping, limit=16'h5959:
  - load_value=16'h0A7C -> value=16'h0959.
  - load and step in the same cycle -> load wins.
  - en=0 with step pulses -> value unchanged.
- init_value=16'h1234, assert reset asynchronously mid-count (between edges) -> value=16'h1234 and flags 0 immediately. Hold for two edges with steps -> unchanged. Release -> counting resumes from 16'h1234.

Source files
------------

// File: rtl/cascade_limit_counter.sv
// Cascaded per-digit limit counter for stopwatch, timer and clock displays.
// Each digit counts 0..limit_i in either direction. Carry and borrow ripple
// combinationally across all digits inside one cycle. The top level adds the
// terminal, stop and pulse handling.

// One digit: computes the next value when stepped, plus the load clip and the
// carry/borrow qualifiers that feed the ripple chain.
module cascade_limit_digit #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] val,
  input  logic [DIGIT_W-1:0] lim,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dir,
  input  logic               stepped,
  output logic [DIGIT_W-1:0] nxt,
  output logic [DIGIT_W-1:0] load_clip,
  output logic               at_hi,
  output logic               at_zero
);
  // A value at or above its limit carries out. This also covers values that
  // exceed a limit which was lowered at runtime.
  assign at_hi     = (val >= lim);
  assign at_zero   = (val == '0);
  assign load_clip = (load_val > lim) ? lim : load_val;

  // Next-value selection for a stepped digit, in either direction.
  always_comb begin
    nxt = val;
    if (stepped) begin
      if (dir) nxt = at_hi   ? '0  : val + DIGIT_W'(1);
      else     nxt = at_zero ? lim : val - DIGIT_W'(1);
    end
  end
endmodule

module cascade_limit_counter #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          step,
  input  logic                          dir,
  input  logic                          wrap_mode,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] init_value,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] limit,
  output logic [NUM_DIGITS*DIGIT_W-1:0] value,
  output logic                          carry_pulse,
  output logic                          at_terminal,
  output logic                          stopped
);
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] val_d, lim_d, ldv_d, nxt_d, clip_d;
  logic [NUM_DIGITS-1:0]              hi, zero, stepped_d;
  // up_rip[i] / dn_rip[i]: every digit below i carries / borrows.
  logic [NUM_DIGITS:0]                up_rip, dn_rip;
  logic                               active;

  assign val_d = value;
  assign lim_d = limit;
  assign ldv_d = load_value;

  assign up_rip[0] = 1'b1;
  assign dn_rip[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign up_rip[g+1]  = up_rip[g] & hi[g];
    assign dn_rip[g+1]  = dn_rip[g] & zero[g];
    assign stepped_d[g] = dir ? up_rip[g] : dn_rip[g];

    cascade_limit_digit #(.DIGIT_W(DIGIT_W)) u_dig (
      .val       (val_d[g]),
      .lim       (lim_d[g]),
      .load_val  (ldv_d[g]),
      .dir       (dir),
      .stepped   (stepped_d[g]),
      .nxt       (nxt_d[g]),
      .load_clip (clip_d[g]),
      .at_hi     (hi[g]),
      .at_zero   (zero[g])
    );
  end

  // Terminal is where a step would carry or borrow out of the top digit.
  // It follows dir directly and is not registered.
  assign at_terminal = dir ? up_rip[NUM_DIGITS] : dn_rip[NUM_DIGITS];
  assign active      = en & step & ~stopped;

  // Count state: reset > load > active step > hold. carry_pulse is high only
  // in the cycle after a wrapping step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value       <= init_value;
      carry_pulse <= 1'b0;
      stopped     <= 1'b0;
    end else if (load) begin
      value       <= clip_d;
      carry_pulse <= 1'b0;
      stopped     <= 1'b0;
    end else if (active) begin
      if (at_terminal && !wrap_mode) begin
        stopped     <= 1'b1;
        carry_pulse <= 1'b0;
      end else begin
        value       <= nxt_d;
        carry_pulse <= at_terminal;
      end
    end else begin
      carry_pulse <= 1'b0;
    end
  end
endmodule
